// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the fetch port and the data port.
// The data port has priority, but it cannot re-win the grant in its own DONE cycle.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_VALID,
  output logic              IF_STALL,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic              DM_VALID,
  output logic              DM_STALL,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  logic [3:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_valid;
  logic              r_dm_valid;
  logic              w_grant_if;
  logic              w_grant_dm;
  logic              w_capture;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_en   <= w_grant_if | w_grant_dm;
      r_if_valid <= w_capture & (r_owner == OWN_IF);
      r_dm_valid <= w_capture & (r_owner == OWN_DM);
      if (w_grant_dm) begin
        r_owner     <= OWN_DM;
        r_mem_we    <= DM_WE;
        r_mem_addr  <= DM_ADDR;
        r_mem_wdata <= DM_WDATA;
        r_cnt       <= LAT_INIT;
      end else if (w_grant_if) begin
        r_owner    <= OWN_IF;
        r_mem_we   <= 1'b0;
        r_mem_addr <= IF_ADDR;
        r_cnt      <= LAT_INIT;
      end else if (r_state == ST_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Stores complete without touching the read-data register.
      if (w_capture && !r_mem_we) begin
        if (r_owner == OWN_IF) r_if_rdata <= MEM_RDATA;
        else                   r_dm_rdata <= MEM_RDATA;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_if || w_grant_dm) w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = (w_grant_if || w_grant_dm) ? ST_BUSY : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // In DONE only the port that did not just complete may be granted.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_dm = DM_REQ;
        w_grant_if = IF_REQ & ~DM_REQ;
      end
      ST_BUSY: w_capture = (r_cnt == '0);
      ST_DONE: begin
        w_grant_dm = DM_REQ & (r_owner == OWN_IF);
        w_grant_if = IF_REQ & (r_owner == OWN_DM);
      end
      default: ;
    endcase
  end

  assign IF_RDATA  = r_if_rdata;
  assign IF_VALID  = r_if_valid;
  assign IF_STALL  = IF_REQ & ~r_if_valid;
  assign DM_RDATA  = r_dm_rdata;
  assign DM_VALID  = r_dm_valid;
  assign DM_STALL  = DM_REQ & ~r_dm_valid;
  assign MEM_EN    = r_mem_en;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (MEM_LAT 2, 1, 15) are exercised in turn.
// Each runs directed cases and then random traffic against an access-schedule reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NL];
  logic        if_req    [NL];
  logic [31:0] if_addr   [NL];
  logic [31:0] if_rdata  [NL];
  logic        if_valid  [NL];
  logic        if_stall  [NL];
  logic        dm_req    [NL];
  logic        dm_we     [NL];
  logic [31:0] dm_addr   [NL];
  logic [31:0] dm_wdata  [NL];
  logic [31:0] dm_rdata  [NL];
  logic        dm_valid  [NL];
  logic        dm_stall  [NL];
  logic        mem_en    [NL];
  logic        mem_we    [NL];
  logic [31:0] mem_addr  [NL];
  logic [31:0] mem_wdata [NL];
  logic [31:0] mem_rdata [NL];

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    localparam int unsigned LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .CLOCK(clk), .RESET(rst[gi]),
      .IF_REQ(if_req[gi]), .IF_ADDR(if_addr[gi]), .IF_RDATA(if_rdata[gi]),
      .IF_VALID(if_valid[gi]), .IF_STALL(if_stall[gi]),
      .DM_REQ(dm_req[gi]), .DM_WE(dm_we[gi]), .DM_ADDR(dm_addr[gi]),
      .DM_WDATA(dm_wdata[gi]), .DM_RDATA(dm_rdata[gi]),
      .DM_VALID(dm_valid[gi]), .DM_STALL(dm_stall[gi]),
      .MEM_EN(mem_en[gi]), .MEM_WE(mem_we[gi]), .MEM_ADDR(mem_addr[gi]),
      .MEM_WDATA(mem_wdata[gi]), .MEM_RDATA(mem_rdata[gi])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  int unsigned k, lat;
  int          cyc;
  // Reference model: one access at a time, granted at the end of cycle m_g.
  bit          m_busy, m_own_dm, m_we, m_after_rst;
  int          m_g;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic [31:0] ref_mem [16];
  // Memory environment reacting to the DUT's memory port.
  logic [31:0] env_mem [16];
  int          en_cyc;
  logic [3:0]  en_idx;
  bit          en_we;
  // Requester state.
  bit          if_act, if_rel, dm_act, dm_rel;
  int          if_vcyc, dm_vcyc;

  function automatic string tg(input string s);
    return $sformatf("L%0d_%s", lat, s);
  endfunction

  task automatic model_start(input bit own_dm);
    m_busy   = 1'b1;
    m_own_dm = own_dm;
    m_g      = cyc;
    m_addr   = own_dm ? dm_addr[k] : if_addr[k];
    m_we     = own_dm ? dm_we[k] : 1'b0;
    m_wdata  = dm_wdata[k];
  endtask

  task automatic env_cycle();
    if (mem_en[k]) begin
      en_cyc = cyc;
      en_idx = mem_addr[k][5:2];
      en_we  = mem_we[k];
      if (mem_we[k]) env_mem[en_idx] = mem_wdata[k];
    end
    if (cyc == en_cyc + int'(lat) && !en_we) mem_rdata[k] = env_mem[en_idx];
    else                                     mem_rdata[k] = $urandom();
  endtask

  task automatic step();
    bit e_en, fin, e_ifv, e_dmv;
    @(negedge clk);
    e_en  = m_busy && (cyc == m_g + 1);
    fin   = m_busy && (cyc == m_g + int'(lat) + 2);
    e_ifv = fin && !m_own_dm;
    e_dmv = fin && m_own_dm;
    if (e_en && m_we) ref_mem[m_addr[5:2]] = m_wdata;
    if (e_ifv) m_if_rdata = ref_mem[m_addr[5:2]];
    if (e_dmv && !m_we) m_dm_rdata = ref_mem[m_addr[5:2]];
    check(tg("mem_en"), 32'(mem_en[k]), 32'(e_en));
    if (e_en) begin
      check(tg("mem_addr"), mem_addr[k], m_addr);
      check(tg("mem_we"), 32'(mem_we[k]), 32'(m_we));
    end
    if (e_en && m_we) check(tg("mem_wdata"), mem_wdata[k], m_wdata);
    if (m_after_rst) begin
      check(tg("rst_mem_addr"), mem_addr[k], '0);
      check(tg("rst_mem_wdata"), mem_wdata[k], '0);
      check(tg("rst_mem_we"), 32'(mem_we[k]), '0);
    end
    check(tg("if_valid"), 32'(if_valid[k]), 32'(e_ifv));
    check(tg("dm_valid"), 32'(dm_valid[k]), 32'(e_dmv));
    check(tg("if_rdata"), if_rdata[k], m_if_rdata);
    check(tg("dm_rdata"), dm_rdata[k], m_dm_rdata);
    check(tg("if_stall"), 32'(if_stall[k]), 32'(if_req[k] & ~e_ifv));
    check(tg("dm_stall"), 32'(dm_stall[k]), 32'(dm_req[k] & ~e_dmv));
    m_after_rst = rst[k];
    if (rst[k]) begin
      m_busy     = 1'b0;
      m_if_rdata = '0;
      m_dm_rdata = '0;
    end else if (fin) begin
      m_busy = 1'b0;
      if (m_own_dm && if_req[k])       model_start(1'b0);
      else if (!m_own_dm && dm_req[k]) model_start(1'b1);
    end else if (!m_busy) begin
      if (dm_req[k])      model_start(1'b1);
      else if (if_req[k]) model_start(1'b0);
    end
    @(posedge clk);
    #1;
    cyc++;
    env_cycle();
  endtask

  task automatic new_if(input logic [31:0] a);
    if_act     = 1'b1;
    if_req[k]  = 1'b1;
    if_addr[k] = a;
  endtask

  task automatic new_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    dm_act      = 1'b1;
    dm_req[k]   = 1'b1;
    dm_we[k]    = we;
    dm_addr[k]  = a;
    dm_wdata[k] = d;
  endtask

  task automatic clear_ports();
    if_act = 0; if_rel = 0; dm_act = 0; dm_rel = 0;
    if_req[k] = 1'b0;
    dm_req[k] = 1'b0;
  endtask

  // Requests are held through the VALID cycle and released on the following one.
  task automatic drive_ports(input bit allow_new);
    if (if_act && if_valid[k]) begin
      if_vcyc = cyc; if_act = 0; if_rel = 1;
    end else if (if_rel) begin
      if_rel = 0; if_req[k] = 1'b0;
      if (allow_new && $urandom_range(0, 3) != 0) new_if($urandom());
    end else if (!if_act && allow_new && $urandom_range(0, 1) == 1) begin
      new_if($urandom());
    end
    if (dm_act && dm_valid[k]) begin
      dm_vcyc = cyc; dm_act = 0; dm_rel = 1;
    end else if (dm_rel) begin
      dm_rel = 0; dm_req[k] = 1'b0;
      if (allow_new && $urandom_range(0, 3) != 0) new_dm(1'($urandom()), $urandom(), $urandom());
    end else if (!dm_act && allow_new && $urandom_range(0, 2) == 0) begin
      new_dm(1'($urandom()), $urandom(), $urandom());
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive_ports(1'b0);
      if (!(if_act || if_rel || dm_act || dm_rel)) break;
    end
  endtask

  task automatic run(input int unsigned kk, input int unsigned ll);
    int t0, nv;
    logic [31:0] v;
    k = kk; lat = ll; cyc = 0;
    m_busy = 0; m_after_rst = 1; m_if_rdata = '0; m_dm_rdata = '0; m_g = -100;
    en_cyc = -100; en_we = 0; en_idx = '0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom();
      ref_mem[i] = v;
      env_mem[i] = v;
    end
    env_mem[0] = 32'h8C01_0004;
    ref_mem[0] = 32'h8C01_0004;
    clear_ports();
    rst[k] = 1'b1;
    @(posedge clk);
    #1;
    step();
    rst[k] = 1'b0;

    // Lone fetch.
    t0 = cyc; if_vcyc = -1;
    new_if(32'h0000_0040);
    run_idle(40);
    check(tg("t1_if_lat"), 32'(if_vcyc - t0), 32'(lat + 2));
    step();

    // Simultaneous requests: data first, fetch granted at data's DONE edge.
    t0 = cyc; if_vcyc = -1; dm_vcyc = -1;
    new_if(32'h0000_0040);
    new_dm(1'b0, 32'h0000_0100, '0);
    run_idle(80);
    check(tg("t2_dm_lat"), 32'(dm_vcyc - t0), 32'(lat + 2));
    check(tg("t2_if_lat"), 32'(if_vcyc - t0), 32'(2 * lat + 4));
    step();

    // Store.
    t0 = cyc; dm_vcyc = -1;
    new_dm(1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
    run_idle(40);
    check(tg("t3_st_lat"), 32'(dm_vcyc - t0), 32'(lat + 2));
    step();

    // Reset in the second BUSY cycle abandons the access.
    new_if(32'h0000_0080);
    step();
    step();
    rst[k] = 1'b1;
    step();
    rst[k] = 1'b0;
    clear_ports();
    nv = 0;
    for (int i = 0; i < int'(lat) + 4; i++) begin
      step();
      nv += int'(if_valid[k]) + int'(dm_valid[k]);
    end
    check(tg("t5_no_valid"), 32'(nv), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1200; i++) begin
      if (rst[k]) begin
        rst[k] = 1'b0;
        clear_ports();
      end else begin
        drive_ports(1'b1);
      end
      rst[k] = ($urandom_range(0, 99) == 0);
      step();
    end
    rst[k] = 1'b0;
    run_idle(60);
    step();
    rst[k] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < int'(NL); i++) begin
      rst[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = '0;
      dm_req[i] = 1'b0; dm_we[i] = 1'b0; dm_addr[i] = '0; dm_wdata[i] = '0;
      mem_rdata[i] = '0;
    end
    run(0, 2);
    run(1, 1);
    run(2, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
